// File: rtl/return_addr_stack.sv
// -----------------------------------------------------------------------------
// return_addr_stack
//
// Hardware return-address stack for CALL/RET. The ID-stage control unit raises
// push (CALL) or pop (RET) and holds the level for the whole instruction, which
// can last several cycles. This block turns each level into a single event in
// its first cycle, so a held level pushes or pops only once.
//
// Strobe semantics: push/pop are levels, not valid/ready handshakes. An event
// fires in the cycle a level rises (level high now, low in the previous cycle).
// The block never stalls: every event takes effect at the next rising clock
// edge. An event that cannot complete sets a sticky error flag.
//
// Ports
//   clk        in   1          clock, all state updates on rising edge
//   reset      in   1          synchronous, active-high
//   push       in   1          CALL level from control unit
//   pop        in   1          RET level from control unit
//   pc_in      in   ADDR_W     return address stored on push
//   err_clr    in   1          clears sticky overflow/underflow flags
//   top_out    out  ADDR_W     current top of stack (combinational, 0 if empty)
//   count      out  PTR_W+1    number of valid entries, 0..DEPTH
//   empty      out  1          count == 0
//   full       out  1          count == DEPTH
//   overflow   out  1          sticky: push attempted while full
//   underflow  out  1          sticky: pop attempted while empty
// -----------------------------------------------------------------------------
module return_addr_stack #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] top_out,
    output logic [PTR_W:0]    count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [PTR_W:0] SP_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0] SP_FULL = (PTR_W + 1)'(DEPTH);

    // Storage is deliberately not reset; only the pointer defines validity.
    logic [ADDR_W-1:0] mem_q [DEPTH];

    logic [PTR_W:0] sp_q, sp_d;
    logic           push_q, pop_q;
    logic           overflow_q, overflow_d;
    logic           underflow_q, underflow_d;

    logic             push_ev, pop_ev;
    logic             is_empty, is_full;
    logic [PTR_W:0]   sp_dec;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] wr_addr;
    logic             wr_en;

    assign push_ev = push & ~push_q;
    assign pop_ev  = pop & ~pop_q;

    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == SP_FULL);

    // sp is one past the top entry; with sp == DEPTH the truncated index is
    // DEPTH-1, which is exactly the top.
    assign sp_dec  = sp_q - SP_ONE;
    assign top_idx = sp_dec[PTR_W-1:0];

    // Next-state logic for pointer, flags and the single memory write port.
    always_comb begin
        sp_d        = sp_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        wr_en       = 1'b0;
        wr_addr     = sp_q[PTR_W-1:0];

        // Clear first so that an error event in the same cycle overrides it.
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end

        if (push_ev && pop_ev) begin
            if (is_empty) begin
                // Nothing to pop: still perform the push, but flag the pop.
                wr_en       = 1'b1;
                wr_addr     = '0;
                sp_d        = SP_ONE;
                underflow_d = 1'b1;
            end else begin
                // Tail-call style replace of the top entry.
                wr_en   = 1'b1;
                wr_addr = top_idx;
            end
        end else if (push_ev) begin
            if (is_full) begin
                overflow_d = 1'b1;
            end else begin
                wr_en   = 1'b1;
                wr_addr = sp_q[PTR_W-1:0];
                sp_d    = sp_q + SP_ONE;
            end
        end else if (pop_ev) begin
            if (is_empty) begin
                underflow_d = 1'b1;
            end else begin
                sp_d = sp_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q        <= '0;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            push_q      <= push;
            pop_q       <= pop;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Writes are suppressed during reset so a coincident push leaves no trace.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem_q[wr_addr] <= pc_in;
        end
    end

    // During a pop event cycle sp has not moved yet, so top_out still shows
    // the value being returned to.
    assign top_out   = is_empty ? '0 : mem_q[top_idx];
    assign count     = sp_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_return_addr_stack.sv
module tb_return_addr_stack;

    localparam int ADDR_W = 16;
    localparam int DEPTH  = 8;
    localparam int PTR_W  = 3;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              reset;
    logic              push, pop, err_clr;
    logic [ADDR_W-1:0] pc_in;
    logic [ADDR_W-1:0] top_out;
    logic [PTR_W:0]    count;
    logic              empty, full, overflow, underflow;

    always #5 clk = ~clk;

    return_addr_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .pc_in    (pc_in),
        .err_clr  (err_clr),
        .top_out  (top_out),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .underflow(underflow)
    );

    // ---------------- scoreboard ----------------
    logic [ADDR_W-1:0] exp_q[$];     // reference stack, back = top
    logic              exp_ovf;
    logic              exp_udf;
    int                n_checks = 0;
    int                n_pass   = 0;
    int                n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive point: 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_op(input logic [ADDR_W-1:0] pc, input int hold);
        if (exp_q.size() < DEPTH) exp_q.push_back(pc);
        else exp_ovf = 1'b1;
        push  = 1'b1;
        pc_in = pc;
        repeat (hold) tick();
        push = 1'b0;
        tick();
    endtask

    task automatic pop_op(input string tag, input int hold);
        logic [ADDR_W-1:0] exp_top;
        if (exp_q.size() > 0) exp_top = exp_q.pop_back();
        else begin
            exp_top = '0;
            exp_udf = 1'b1;
        end
        pop = 1'b1;
        @(negedge clk);
        check(tag, 32'(top_out), 32'(exp_top));
        repeat (hold) tick();
        pop = 1'b0;
        tick();
    endtask

    task automatic check_state(input string tag);
        logic [ADDR_W-1:0] exp_top;
        exp_top = (exp_q.size() > 0) ? exp_q[$] : '0;
        check({tag, ".count"}, 32'(count), 32'(exp_q.size()));
        check({tag, ".top"}, 32'(top_out), 32'(exp_top));
        check({tag, ".empty"}, 32'(empty), 32'(exp_q.size() == 0));
        check({tag, ".full"}, 32'(full), 32'(exp_q.size() == DEPTH));
        check({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
        check({tag, ".udf"}, 32'(underflow), 32'(exp_udf));
    endtask

    task automatic clear_flags();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset   = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        err_clr = 1'b0;
        pc_in   = '0;
        exp_ovf = 1'b0;
        exp_udf = 1'b0;

        // T1 reset
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check_state("t1_reset");

        // T2 push/pop order, 5-cycle held levels
        push_op(16'h0010, 5);
        push_op(16'h0020, 5);
        push_op(16'h0030, 5);
        check_state("t2_after_push");
        pop_op("t2_pop0", 5);
        pop_op("t2_pop1", 5);
        pop_op("t2_pop2", 5);
        check_state("t2_drained");

        // T3 fill, overflow, error clear, drain
        for (int i = 0; i < DEPTH; i++) push_op(16'h0100 + 16'(i), $urandom_range(1, 5));
        push_op(16'hFFFF, 2);
        check_state("t3_full");
        clear_flags();
        check_state("t3_clr");
        for (int i = 0; i < DEPTH; i++) pop_op("t3_drain", $urandom_range(1, 5));
        check_state("t3_drained");

        // T4 underflow on empty stack
        pop_op("t4_pop_empty", 3);
        check_state("t4_udf");
        clear_flags();
        check_state("t4_clr");

        // Error event coincident with err_clr: the set must win
        err_clr = 1'b1;
        pop     = 1'b1;
        exp_udf = 1'b1;
        tick();
        err_clr = 1'b0;
        pop     = 1'b0;
        tick();
        check_state("set_beats_clr");
        clear_flags();

        // T5 simultaneous push+pop replaces top
        push_op(16'h0040, 2);
        push  = 1'b1;
        pop   = 1'b1;
        pc_in = 16'h0050;
        exp_q[exp_q.size() - 1] = 16'h0050;
        repeat (3) tick();
        push = 1'b0;
        pop  = 1'b0;
        tick();
        check_state("t5_replace");
        pop_op("t5_pop", 2);

        // Simultaneous push+pop on an empty stack: push happens, underflow flags
        push  = 1'b1;
        pop   = 1'b1;
        pc_in = 16'h0055;
        exp_q.push_back(16'h0055);
        exp_udf = 1'b1;
        tick();
        push = 1'b0;
        pop  = 1'b0;
        tick();
        check_state("both_on_empty");
        pop_op("both_on_empty_pop", 1);
        clear_flags();

        // T6 long held push yields one entry; pc_in changes mid-hold
        exp_q.push_back(16'h0060);
        push  = 1'b1;
        pc_in = 16'h0060;
        tick();
        pc_in = 16'h0061;
        repeat (9) tick();
        push = 1'b0;
        tick();
        check_state("t6_held");

        // Reset coincident with a push rising edge discards the push
        reset = 1'b1;
        push  = 1'b1;
        pc_in = 16'h0070;
        tick();
        reset = 1'b0;
        push  = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        tick();
        check_state("t6_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
